// File: rtl/fp_mant_multiplier_pkg.sv
// rtl/fp_mant_multiplier_pkg.sv - shared binary32 constants, FSM state type and field helpers
package fp_mant_multiplier_pkg;

    localparam int MANT_W    = 23;
    localparam int EXP_W     = 8;
    localparam int SIG_W     = 24;
    localparam int PROD_W    = 48;
    localparam int EXP_SUM_W = 10;
    localparam int EXP_BIAS  = 127;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic logic f_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [EXP_W-1:0] f_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [MANT_W-1:0] f_mant(input logic [31:0] x);
        return x[22:0];
    endfunction

endpackage

// File: rtl/fp_mant_multiplier_if.sv
// rtl/fp_mant_multiplier_if.sv - operand/result handshake bundle for the mantissa multiplier
interface fp_mant_multiplier_if;
    import fp_mant_multiplier_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          op_a;
    logic [31:0]          op_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [PROD_W-1:0]    product;
    logic [EXP_SUM_W-1:0] exp_sum;
    logic                 sign;
    logic                 is_zero;
    logic                 is_special;

    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, product, exp_sum, sign, is_zero, is_special
    );

    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, product, exp_sum, sign, is_zero, is_special
    );

endinterface

// File: rtl/fp_mant_multiplier_core.sv
// rtl/fp_mant_multiplier_core.sv - iterative shift-add 24x24 significand multiplier
module fp_shift_add_core
    import fp_mant_multiplier_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SIG_W-1:0]  multiplicand,
    input  logic [SIG_W-1:0]  multiplier,
    output logic              done,
    output logic [PROD_W-1:0] result
);

    localparam int STEPS = SIG_W / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS);

    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] acc_next;
    logic [PROD_W-1:0] mcand_sh;
    logic [SIG_W-1:0]  mplier;
    logic [CNT_W-1:0]  cnt;
    logic              busy;

    // Partial products for the multiplier bits retired this cycle; the
    // multiplicand is pre-shifted so bit j only needs a further shift by j.
    always_comb begin
        acc_next = acc;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (mplier[j]) begin
                acc_next = acc_next + (mcand_sh << j);
            end
        end
    end

    // Accumulate/shift engine; done pulses together with the final add so
    // result is already complete when done is seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            mcand_sh <= '0;
            mplier   <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (start) begin
            acc      <= '0;
            mcand_sh <= {{(PROD_W-SIG_W){1'b0}}, multiplicand};
            mplier   <= multiplier;
            cnt      <= CNT_W'(STEPS - 1);
            busy     <= 1'b1;
            done     <= 1'b0;
        end else if (busy) begin
            acc      <= acc_next;
            mcand_sh <= mcand_sh << BITS_PER_CYCLE;
            mplier   <= mplier >> BITS_PER_CYCLE;
            done     <= (cnt == '0);
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

    assign result = acc;

endmodule

// File: rtl/fp_mant_multiplier.sv
// rtl/fp_mant_multiplier.sv - binary32 multiply front end: unpack, sign/exponent, significand product
module fp_mant_multiplier #(
    parameter int BITS_PER_CYCLE = 1,
    parameter int EXP_BIAS       = fp_mant_multiplier_pkg::EXP_BIAS
) (
    input  logic                 clk,
    input  logic                 reset,
    fp_mant_multiplier_if.slave  bus
);
    import fp_mant_multiplier_pkg::*;

    state_t               state;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [PROD_W-1:0]    product_r;
    logic [EXP_SUM_W-1:0] exp_sum_r;
    logic                 sign_r;
    logic                 is_zero_r;
    logic                 is_special_r;
    logic                 bypass;

    logic [EXP_W-1:0]     exp_a;
    logic [EXP_W-1:0]     exp_b;
    logic                 any_zero;
    logic                 any_special;
    logic [EXP_SUM_W-1:0] exp_sum_next;
    logic                 accept;
    logic                 core_start;
    logic                 core_done;
    logic [PROD_W-1:0]    core_result;

    assign exp_a        = f_exp(bus.op_a);
    assign exp_b        = f_exp(bus.op_b);
    assign any_zero     = (exp_a == '0) || (exp_b == '0);
    assign any_special  = (exp_a == EXP_MAX) || (exp_b == EXP_MAX);
    assign exp_sum_next = {2'b00, exp_a} + {2'b00, exp_b} - EXP_SUM_W'(EXP_BIAS);

    assign accept     = bus.in_valid && in_ready_r;
    assign core_start = accept && !any_zero && !any_special;

    fp_shift_add_core #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_core (
        .clk          (clk),
        .reset        (reset),
        .start        (core_start),
        .multiplicand ({1'b1, f_mant(bus.op_a)}),
        .multiplier   ({1'b1, f_mant(bus.op_b)}),
        .done         (core_done),
        .result       (core_result)
    );

    // Handshake FSM with registered outputs. Zero/special operands skip the
    // engine but still pass through one CALC cycle so out_valid rises one
    // cycle after the accept edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            product_r    <= '0;
            exp_sum_r    <= '0;
            sign_r       <= 1'b0;
            is_zero_r    <= 1'b0;
            is_special_r <= 1'b0;
            bypass       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_ready_r   <= 1'b0;
                        sign_r       <= f_sign(bus.op_a) ^ f_sign(bus.op_b);
                        exp_sum_r    <= exp_sum_next;
                        is_special_r <= any_special;
                        is_zero_r    <= any_zero && !any_special;
                        bypass       <= any_zero || any_special;
                        product_r    <= '0;
                        state        <= CALC;
                    end
                end
                CALC: begin
                    if (bypass || core_done) begin
                        product_r   <= bypass ? '0 : core_result;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.product    = product_r;
    assign bus.exp_sum    = exp_sum_r;
    assign bus.sign       = sign_r;
    assign bus.is_zero    = is_zero_r;
    assign bus.is_special = is_special_r;

endmodule

// File: tb/tb_fp_mant_multiplier.sv
// tb/tb_fp_mant_multiplier.sv - scoreboard bench for fp_mant_multiplier at one and two bits per cycle
module tb_fp_mant_multiplier;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    fp_mant_multiplier_if bus0 ();
    fp_mant_multiplier_if bus1 ();

    fp_mant_multiplier #(.BITS_PER_CYCLE(1), .EXP_BIAS(127)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    fp_mant_multiplier #(.BITS_PER_CYCLE(2), .EXP_BIAS(127)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    typedef struct {
        logic [47:0] prod;
        logic [9:0]  exp;
        logic        sgn;
        logic        zero;
        logic        spec;
        int          t0;
        int          lat;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic        pv[2];
    logic [60:0] snap[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic mon_step(input int w);
        logic        v, r, ir, s, z, sp;
        logic [47:0] p;
        logic [9:0]  e;
        exp_t        x;
        int          n;
        if (w == 0) begin
            v = bus0.out_valid; r = bus0.out_ready; ir = bus0.in_ready;
            p = bus0.product; e = bus0.exp_sum; s = bus0.sign;
            z = bus0.is_zero; sp = bus0.is_special; n = q0.size();
            if (n > 0) x = q0[0];
        end else begin
            v = bus1.out_valid; r = bus1.out_ready; ir = bus1.in_ready;
            p = bus1.product; e = bus1.exp_sum; s = bus1.sign;
            z = bus1.is_zero; sp = bus1.is_special; n = q1.size();
            if (n > 0) x = q1[0];
        end
        if (v) begin
            chk("in_ready_low_while_valid", 64'(ir), 64'd0);
            if (!pv[w]) begin
                if (n == 0) chk("unexpected_result", 64'd1, 64'd0);
                else chk("latency", 64'(cyc - x.t0), 64'(x.lat));
                snap[w] = {p, e, s, z, sp};
            end else begin
                chk("held_outputs_stable", 64'({p, e, s, z, sp}), 64'(snap[w]));
            end
            if (r && n > 0) begin
                chk("product", 64'(p), 64'(x.prod));
                chk("exp_sum", 64'(e), 64'(x.exp));
                chk("sign", 64'(s), 64'(x.sgn));
                chk("is_zero", 64'(z), 64'(x.zero));
                chk("is_special", 64'(sp), 64'(x.spec));
                if (w == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
            end
        end
        pv[w] = v;
    endtask

    // Monitor: compares every result the DUTs present against the queued expectation.
    always @(negedge clk) begin
        mon_step(0);
        mon_step(1);
    end

    function automatic logic rdy(input int w);
        return (w == 0) ? bus0.in_ready : bus1.in_ready;
    endfunction

    task automatic drive(input int w, input logic v, input logic [31:0] a, input logic [31:0] b);
        if (w == 0) begin
            bus0.in_valid = v; bus0.op_a = a; bus0.op_b = b;
        end else begin
            bus1.in_valid = v; bus1.op_a = a; bus1.op_b = b;
        end
    endtask

    task automatic issue(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic [47:0] p, input logic [9:0] e,
                         input logic s, input logic z, input logic sp, input int lat);
        int   n = 0;
        exp_t x;
        @(negedge clk);
        drive(w, 1'b1, a, b);
        while (!rdy(w) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("accept_timeout", 64'd1, 64'd0);
            drive(w, 1'b0, a, b);
            return;
        end
        @(posedge clk);
        #1;
        x = '{prod: p, exp: e, sgn: s, zero: z, spec: sp, t0: cyc, lat: lat};
        if (w == 0) q0.push_back(x);
        else q1.push_back(x);
        @(negedge clk);
        drive(w, 1'b0, a, b);
    endtask

    task automatic wait_drain(input int w);
        int n = 0;
        while (((w == 0) ? (q0.size() != 0 || bus0.out_valid) : (q1.size() != 0 || bus1.out_valid))
               && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_in_ready"}, 64'(bus0.in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(bus0.out_valid), 64'd0);
        chk({tag, "_product"}, 64'(bus0.product), 64'd0);
        chk({tag, "_exp_sum"}, 64'(bus0.exp_sum), 64'd0);
        chk({tag, "_flags"}, 64'({bus0.sign, bus0.is_zero, bus0.is_special}), 64'd0);
    endtask

    initial begin
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        drive(0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 32'h0, 32'h0);
        bus0.out_ready = 1'b1;
        bus1.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_cleared("reset_state");

        issue(0, 32'h3F800000, 32'h3F800000, 48'h4000_0000_0000, 10'd127, 1'b0, 1'b0, 1'b0, 25);
        wait_drain(0);
        issue(0, 32'h3FC00000, 32'h3FC00000, 48'h9000_0000_0000, 10'd127, 1'b0, 1'b0, 1'b0, 25);
        wait_drain(0);
        issue(1, 32'h3FC00000, 32'h3FC00000, 48'h9000_0000_0000, 10'd127, 1'b0, 1'b0, 1'b0, 13);
        wait_drain(1);
        issue(0, 32'hC0000000, 32'h40400000, 48'h6000_0000_0000, 10'd129, 1'b1, 1'b0, 1'b0, 25);
        wait_drain(0);
        issue(0, 32'h00000000, 32'h40400000, 48'h0, 10'd1, 1'b0, 1'b1, 1'b0, 1);
        wait_drain(0);
        issue(0, 32'h80000000, 32'h40400000, 48'h0, 10'd1, 1'b1, 1'b1, 1'b0, 1);
        wait_drain(0);
        issue(0, 32'h7F800000, 32'h40000000, 48'h0, 10'h100, 1'b0, 1'b0, 1'b1, 1);
        wait_drain(0);

        bus0.out_ready = 1'b0;
        issue(0, 32'h00800000, 32'h00800000, 48'h4000_0000_0000, 10'h383, 1'b0, 1'b0, 1'b0, 25);
        begin
            int n = 0;
            while (!bus0.out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) chk("valid_timeout", 64'd1, 64'd0);
        end
        @(negedge clk);
        drive(0, 1'b1, 32'h3F800000, 32'h3F800000);
        chk("in_ready_during_hold", 64'(bus0.in_ready), 64'd0);
        @(negedge clk);
        drive(0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 bus0.out_ready = 1'b1;
        wait_drain(0);
        repeat (30) @(negedge clk);
        chk("ignored_pulse_no_result", 64'(bus0.out_valid), 64'd0);

        issue(0, 32'h3F800000, 32'h3F800000, 48'h4000_0000_0000, 10'd127, 1'b0, 1'b0, 1'b0, 25);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q0.delete();
        chk_cleared("abort_reset");
        issue(0, 32'h3F800000, 32'h3F800000, 48'h4000_0000_0000, 10'd127, 1'b0, 1'b0, 1'b0, 25);
        wait_drain(0);
        wait_drain(1);
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
